microstore_sequencer: RTL and testbench

Next-state address sequencer for the microprogrammed control unit. Holds the current control-store state address register and selects each cycle among increment (+1 mod 512), instruction-encoder address, control-register jump target, microsubroutine return, and restart. Adds memory-wait stalls on MOC with a watchdog timeout. Its output drives the microstore ROM address, which feeds the control register that supplies this block's select fields.

---
 rtl/microstore_sequencer_if.sv | 23 ++
 rtl/microstore_sequencer.sv | 151 +++++++++++++++
 tb/tb_microstore_sequencer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/microstore_sequencer_if.sv
// rtl/microstore_sequencer_if.sv - select/target inputs and address/status outputs of the microstore sequencer
interface microstore_sequencer_if;
    logic [2:0] next_sel;
    logic [8:0] cr_addr;
    logic [8:0] enc_addr;
    logic       cond;
    logic       cond_inv;
    logic       moc;
    logic [8:0] state_addr;
    logic       stalled;
    logic       timeout;
    logic       stack_err;

    modport master (
        output next_sel, cr_addr, enc_addr, cond, cond_inv, moc,
        input  state_addr, stalled, timeout, stack_err
    );

    modport slave (
        input  next_sel, cr_addr, enc_addr, cond, cond_inv, moc,
        output state_addr, stalled, timeout, stack_err
    );
endinterface

// File: rtl/microstore_sequencer.sv
// rtl/microstore_sequencer.sv - next-state address sequencer for the microstore; optional return stack under MICRO_STACK_EN
module microstore_sequencer #(
    parameter logic [8:0] RESET_ADDR   = 9'd0,
    parameter logic [8:0] TIMEOUT_ADDR = 9'd511,
    parameter logic [7:0] WAIT_LIMIT   = 8'd255,
    parameter int         STACK_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    microstore_sequencer_if.slave  bus
);
    localparam logic [2:0] SEL_INC  = 3'b000;
    localparam logic [2:0] SEL_ENC  = 3'b001;
    localparam logic [2:0] SEL_JMP  = 3'b010;
    localparam logic [2:0] SEL_CJMP = 3'b011;
    localparam logic [2:0] SEL_WAIT = 3'b100;
    localparam logic [2:0] SEL_CALL = 3'b101;
    localparam logic [2:0] SEL_RET  = 3'b110;

    logic [8:0] addr_q, addr_d;
    logic [8:0] inc;
    logic [7:0] wcnt_q, wcnt_d;
    logic       timeout_q, timeout_d;

    assign inc = addr_q + 9'd1;

`ifdef MICRO_STACK_EN
    localparam int                SP_W    = $clog2(STACK_DEPTH + 1);
    localparam int                IDX_W   = $clog2(STACK_DEPTH);
    localparam logic [SP_W-1:0]   SP_FULL = SP_W'(STACK_DEPTH);

    logic [8:0]      stack_q [STACK_DEPTH];
    logic [SP_W-1:0] sp_q, sp_d;
    logic            err_q, err_d;
    logic            push;
    logic [8:0]      pop_addr;

    // Top of stack sits one below the pointer; pointer never exceeds depth
    assign pop_addr = stack_q[IDX_W'(sp_q - SP_W'(1))];
`else
    // Depth only matters when the stack is built
    logic unused_stack_depth;
    assign unused_stack_depth = ^STACK_DEPTH;
`endif

    // Next-address selection, wait watchdog and stack bookkeeping
    always_comb begin
        addr_d    = inc;
        wcnt_d    = '0;
        timeout_d = 1'b0;
`ifdef MICRO_STACK_EN
        sp_d  = sp_q;
        err_d = err_q;
        push  = 1'b0;
`endif
        case (bus.next_sel)
            SEL_INC:  addr_d = inc;
            SEL_ENC:  addr_d = bus.enc_addr;
            SEL_JMP:  addr_d = bus.cr_addr;
            SEL_CJMP: begin
                if (bus.cond ^ bus.cond_inv) begin
                    addr_d = bus.cr_addr;
                end
            end
            SEL_WAIT: begin
                // moc wins over the watchdog; the counter only runs while holding
                if (!bus.moc) begin
                    if (wcnt_q == WAIT_LIMIT - 8'd1) begin
                        addr_d    = TIMEOUT_ADDR;
                        timeout_d = 1'b1;
                    end else begin
                        addr_d = addr_q;
                        wcnt_d = wcnt_q + 8'd1;
                    end
                end
            end
            SEL_CALL: begin
                addr_d = bus.cr_addr;
`ifdef MICRO_STACK_EN
                // A full stack still takes the jump but loses the return address
                if (sp_q == SP_FULL) begin
                    err_d = 1'b1;
                end else begin
                    push = 1'b1;
                    sp_d = sp_q + SP_W'(1);
                end
`endif
            end
            SEL_RET: begin
`ifdef MICRO_STACK_EN
                if (sp_q == '0) begin
                    addr_d = RESET_ADDR;
                    err_d  = 1'b1;
                end else begin
                    addr_d = pop_addr;
                    sp_d   = sp_q - SP_W'(1);
                end
`else
                addr_d = RESET_ADDR;
`endif
            end
            default: begin
                addr_d = RESET_ADDR;
`ifdef MICRO_STACK_EN
                sp_d = '0;
`endif
            end
        endcase
    end

    // Address, wait counter and one-cycle timeout pulse registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q    <= RESET_ADDR;
            wcnt_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            wcnt_q    <= wcnt_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef MICRO_STACK_EN
    // Stack pointer and sticky overflow/underflow flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sp_q  <= '0;
            err_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            err_q <= err_d;
        end
    end

    // Return-address storage; contents are only meaningful below the pointer
    always_ff @(posedge clk) begin
        if (push) begin
            stack_q[IDX_W'(sp_q)] <= inc;
        end
    end

    assign bus.stack_err = err_q;
`else
    assign bus.stack_err = 1'b0;
`endif

    assign bus.state_addr = addr_q;
    assign bus.stalled    = (bus.next_sel == SEL_WAIT) && !bus.moc;
    assign bus.timeout    = timeout_q;
endmodule

// File: tb/tb_microstore_sequencer.sv
// tb/tb_microstore_sequencer.sv - randomized self-checking bench for microstore_sequencer against a behavioural model
module tb_microstore_sequencer;
    localparam int WL    = 4;
    localparam int DEPTH = 4;
    localparam int RST_A = 0;
    localparam int TO_A  = 511;
`ifdef MICRO_STACK_EN
    localparam bit STACK_ON = 1'b1;
`else
    localparam bit STACK_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    int   m_addr;
    int   m_held;
    bit   m_to;
    bit   m_err;
    int   m_stack[$];

    microstore_sequencer_if bus();

    microstore_sequencer #(
        .RESET_ADDR  (9'd0),
        .TIMEOUT_ADDR(9'd511),
        .WAIT_LIMIT  (8'd4),
        .STACK_DEPTH (4)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_addr = RST_A;
        m_held = 0;
        m_to   = 1'b0;
        m_err  = 1'b0;
        m_stack.delete();
    endtask

    // One sequencer step written from the selection rules, not from the RTL
    task automatic model_step(input int sel, input int cr, input int enc, input bit c, input bit ci, input bit m);
        int  inc;
        int  nxt;
        bit  held;
        inc  = (m_addr + 1) % 512;
        nxt  = inc;
        held = 1'b0;
        m_to = 1'b0;
        case (sel)
            0: nxt = inc;
            1: nxt = enc;
            2: nxt = cr;
            3: nxt = (c != ci) ? cr : inc;
            4: begin
                if (m) nxt = inc;
                else if (m_held + 1 >= WL) begin
                    nxt  = TO_A;
                    m_to = 1'b1;
                end else begin
                    nxt  = m_addr;
                    held = 1'b1;
                end
            end
            5: begin
                nxt = cr;
                if (STACK_ON) begin
                    if (m_stack.size() < DEPTH) m_stack.push_back(inc);
                    else m_err = 1'b1;
                end
            end
            6: begin
                if (STACK_ON && m_stack.size() > 0) nxt = m_stack.pop_back();
                else begin
                    nxt = RST_A;
                    if (STACK_ON) m_err = 1'b1;
                end
            end
            default: begin
                nxt = RST_A;
                m_stack.delete();
            end
        endcase
        m_held = held ? m_held + 1 : 0;
        m_addr = nxt;
    endtask

    task automatic do_cycle(input int sel, input int cr, input int enc, input bit c, input bit ci, input bit m);
        bus.next_sel = 3'(sel);
        bus.cr_addr  = 9'(cr);
        bus.enc_addr = 9'(enc);
        bus.cond     = c;
        bus.cond_inv = ci;
        bus.moc      = m;
        #1;
        check_eq("stalled", 32'(bus.stalled), 32'(sel == 4 && !m));
        model_step(sel, cr, enc, c, ci, m);
        @(posedge clk);
        #1;
        check_eq("state_addr", 32'(bus.state_addr), 32'(m_addr));
        check_eq("timeout", 32'(bus.timeout), 32'(m_to));
        check_eq("stack_err", 32'(bus.stack_err), 32'(m_err));
    endtask

    // Reset between edges: outputs must clear without waiting for a clock
    task automatic async_reset();
        reset_n = 1'b0;
        #1;
        check_eq("arst_state_addr", 32'(bus.state_addr), 32'(RST_A));
        check_eq("arst_timeout", 32'(bus.timeout), 32'd0);
        check_eq("arst_stack_err", 32'(bus.stack_err), 32'd0);
        model_reset();
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL sim_time_limit: got expired expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        int r;
        int sel;
        reset_n      = 1'b0;
        bus.next_sel = 3'd0;
        bus.cr_addr  = 9'd0;
        bus.enc_addr = 9'd0;
        bus.cond     = 1'b0;
        bus.cond_inv = 1'b0;
        bus.moc      = 1'b0;
        model_reset();
        #1;
        check_eq("reset_state_addr", 32'(bus.state_addr), 32'd0);
        check_eq("reset_timeout", 32'(bus.timeout), 32'd0);
        check_eq("reset_stack_err", 32'(bus.stack_err), 32'd0);
        check_eq("reset_stalled", 32'(bus.stalled), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // increment and wrap
        for (int i = 0; i < 3; i++) do_cycle(0, 0, 0, 0, 0, 0);
        check_eq("plan_inc3", 32'(bus.state_addr), 32'd3);
        do_cycle(2, 511, 0, 0, 0, 0);
        do_cycle(0, 0, 0, 0, 0, 0);
        check_eq("plan_wrap", 32'(bus.state_addr), 32'd0);

        // branching
        do_cycle(3, 'h40, 0, 1, 0, 0);
        check_eq("plan_cjmp_taken", 32'(bus.state_addr), 32'h40);
        do_cycle(3, 'h40, 0, 1, 1, 0);
        check_eq("plan_cjmp_inv", 32'(bus.state_addr), 32'h41);
        do_cycle(1, 0, 'h0A5, 0, 0, 0);
        check_eq("plan_enc", 32'(bus.state_addr), 32'h0A5);
        do_cycle(7, 0, 0, 0, 0, 0);

        // memory wait released on the limit cycle, then a full watchdog expiry
        do_cycle(2, 'h10, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) do_cycle(4, 0, 0, 0, 0, 0);
        check_eq("plan_wait_hold", 32'(bus.state_addr), 32'h10);
        do_cycle(4, 0, 0, 0, 0, 1);
        check_eq("plan_wait_release", 32'(bus.state_addr), 32'h11);
        for (int i = 0; i < 4; i++) do_cycle(4, 0, 0, 0, 0, 0);
        check_eq("plan_wdog_addr", 32'(bus.state_addr), 32'd511);
        check_eq("plan_wdog_pulse", 32'(bus.timeout), 32'd1);
        do_cycle(0, 0, 0, 0, 0, 0);

        // call/return, overflow, underflow
        do_cycle(2, 'h20, 0, 0, 0, 0);
        do_cycle(5, 'h100, 0, 0, 0, 0);
        do_cycle(6, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) do_cycle(5, 'h80 + 8 * i, 0, 0, 0, 0);
        check_eq("plan_call5_target", 32'(bus.state_addr), 32'h0A0);
        for (int i = 0; i < 5; i++) do_cycle(6, 0, 0, 0, 0, 0);
        check_eq("plan_ret_empty", 32'(bus.state_addr), 32'd0);

        // async reset in the middle of a held wait restarts the watchdog
        do_cycle(4, 0, 0, 0, 0, 0);
        do_cycle(4, 0, 0, 0, 0, 0);
        async_reset();
        for (int i = 0; i < 4; i++) do_cycle(4, 0, 0, 0, 0, 0);
        do_cycle(0, 0, 0, 0, 0, 0);

        // randomized traffic weighted towards waits and stack activity
        for (int i = 0; i < 800; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2) async_reset();
            if (r < 35) sel = 4;
            else if (r < 38) sel = 7;
            else sel = int'($urandom_range(0, 6));
            do_cycle(sel, int'($urandom_range(0, 511)), int'($urandom_range(0, 511)),
                     bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                     ($urandom_range(0, 9) < 4));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
